// File: rtl/udar_pkg.sv
// Shared UDAR definitions: frame bytes, park position,
// scan sequencer and record serializer state encodings.
package udar_pkg;

  localparam logic [7:0] f_init      = 8'hA0;
  localparam logic [7:0] f_init_ack  = 8'hA1;
  localparam logic [7:0] f_servo     = 8'hA2;
  localparam logic [7:0] f_servo_ack = 8'hA3;
  localparam logic [7:0] f_trig      = 8'hA4;
  localparam logic [7:0] f_trig_ack  = 8'hA5;
  localparam logic [7:0] f_scan_rec  = 8'hAD;

  localparam int PARK_POS  = 150;
  localparam int REC_BYTES = 5;
  localparam int REC_W     = 8 * REC_BYTES;

  typedef enum logic [2:0] {
    SC_IDLE,
    SC_MOVE,
    SC_SETTLE,
    SC_TRIG,
    SC_WAIT,
    SC_SEND,
    SC_STEP,
    SC_FIN
  } scan_state_e;

  typedef enum logic [1:0] {
    RT_IDLE,
    RT_SEND,
    RT_ACK_HI,
    RT_ACK_LO
  } rec_state_e;

  // byte 0 is the most significant byte of the record
  function automatic logic [7:0] rec_byte(
    input logic [REC_W-1:0] rec,
    input logic [2:0]       idx
  );
    return rec[8*(REC_BYTES-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/scan_rec_tx.sv
// 5-byte scan record serializer towards serial_t.
// A record is never truncated; abort is only reported back.
module scan_rec_tx
  import udar_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [REC_W-1:0] rec,
  input  logic             abort_req,
  output logic             done,
  output logic             aborted,
  output logic [7:0]       tx_data,
  output logic             tx_send,
  input  logic             tx_busy
);

  rec_state_e  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        ab_q, ab_d;
  logic        last;

  assign last = (idx_q == 3'(REC_BYTES - 1));

  // state, byte index and latched abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RT_IDLE;
      idx_q   <= '0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ab_q    <= ab_d;
    end
  end

  // handshake sequencing: send, see busy rise, see busy fall
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ab_d    = ab_q;
    if (state_q != RT_IDLE && abort_req) begin
      ab_d = 1'b1;
    end
    unique case (state_q)
      RT_IDLE: begin
        if (start) begin
          idx_d   = '0;
          ab_d    = 1'b0;
          state_d = RT_SEND;
        end
      end
      RT_SEND: begin
        if (!tx_busy) state_d = RT_ACK_HI;
      end
      RT_ACK_HI: begin
        if (tx_busy) state_d = RT_ACK_LO;
      end
      RT_ACK_LO: begin
        if (!tx_busy) begin
          if (last) begin
            state_d = RT_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = RT_SEND;
          end
        end
      end
      default: state_d = RT_IDLE;
    endcase
  end

  // strobe, byte and completion outputs
  always_comb begin
    tx_send = (state_q == RT_SEND) && !tx_busy;
    tx_data = tx_send ? rec_byte(rec, idx_q) : 8'h00;
    done    = (state_q == RT_ACK_LO) && !tx_busy && last;
    aborted = ab_q | abort_req;
  end

endmodule

// File: rtl/scan_sched.sv
// Raster-scan sequencer for the UDAR head: moves servos,
// settles, triggers hcsr04 and streams one record per point.
module scan_sched
  import udar_pkg::*;
#(
  parameter int POS_LEN    = 8,
  parameter int CAP_LEN    = 16,
  parameter int X_MIN      = 50,
  parameter int X_MAX      = 250,
  parameter int X_STEP     = 10,
  parameter int Y_MIN      = 50,
  parameter int Y_MAX      = 250,
  parameter int Y_STEP     = 10,
  parameter int PARK       = PARK_POS,
  parameter int SETTLE_CYC = 1000,
  parameter int MEAS_TO    = 4000,
  parameter int CNT_LEN    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [POS_LEN-1:0] pos_x,
  output logic [POS_LEN-1:0] pos_y,
  output logic               hc_en,
  input  logic               hc_done,
  input  logic [CAP_LEN-1:0] hc_len,
  output logic [7:0]         tx_data,
  output logic               tx_send,
  input  logic               tx_busy
);

  if (X_MIN > X_MAX) begin : g_bad_x
    $error("scan_sched: X_MIN > X_MAX");
  end
  if (Y_MIN > Y_MAX) begin : g_bad_y
    $error("scan_sched: Y_MIN > Y_MAX");
  end

  localparam logic [POS_LEN-1:0] PK   = POS_LEN'(PARK);
  localparam logic [POS_LEN-1:0] XLO  = POS_LEN'(X_MIN);
  localparam logic [POS_LEN-1:0] YLO  = POS_LEN'(Y_MIN);
  localparam logic [POS_LEN:0]   XS   = (POS_LEN+1)'(X_STEP);
  localparam logic [POS_LEN:0]   YS   = (POS_LEN+1)'(Y_STEP);
  localparam logic [POS_LEN:0]   XHI  = (POS_LEN+1)'(X_MAX);
  localparam logic [POS_LEN:0]   YHI  = (POS_LEN+1)'(Y_MAX);
  localparam logic [CNT_LEN-1:0] SETL = CNT_LEN'(SETTLE_CYC - 1);
  localparam logic [CNT_LEN-1:0] TOUT = CNT_LEN'(MEAS_TO - 1);

  scan_state_e          state_q, state_d;
  logic [POS_LEN-1:0]   x_q, x_d, y_q, y_d;
  logic [POS_LEN-1:0]   px_q, px_d, py_q, py_d;
  logic [CNT_LEN-1:0]   cnt_q, cnt_d;
  logic [CAP_LEN-1:0]   len_q, len_d;
  logic [POS_LEN:0]     x_nx, y_nx;
  logic                 x_fit, y_fit;
  logic [REC_W-1:0]     rec;
  logic                 rec_start, rec_abort;
  logic                 rec_done, rec_aborted;

  // one extra bit so a step past the top bound cannot wrap
  assign x_nx  = {1'b0, x_q} + XS;
  assign y_nx  = {1'b0, y_q} + YS;
  assign x_fit = (x_nx <= XHI);
  assign y_fit = (y_nx <= YHI);

  assign rec = {f_scan_rec, 8'(x_q), 8'(y_q), 16'(len_q)};

  assign pos_x = px_q;
  assign pos_y = py_q;

  // state register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SC_IDLE;
      x_q     <= XLO;
      y_q     <= YLO;
      px_q    <= PK;
      py_q    <= PK;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // next state: grid walk, settle/timeout counting, abort
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    px_d    = px_q;
    py_d    = py_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      SC_IDLE: begin
        if (start) begin
          x_d     = XLO;
          y_d     = YLO;
          px_d    = XLO;
          py_d    = YLO;
          state_d = SC_MOVE;
        end
      end
      SC_MOVE: begin
        cnt_d   = '0;
        state_d = SC_SETTLE;
      end
      SC_SETTLE: begin
        if (cnt_q == SETL) begin
          state_d = SC_TRIG;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SC_TRIG: begin
        if (!hc_done) begin
          cnt_d   = '0;
          state_d = SC_WAIT;
        end
      end
      SC_WAIT: begin
        if (hc_done) begin
          len_d   = hc_len;
          state_d = SC_SEND;
        end else if (cnt_q == TOUT) begin
          len_d   = '1;
          state_d = SC_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SC_SEND: begin
        if (rec_done) begin
          state_d = rec_aborted ? SC_IDLE : SC_STEP;
        end
      end
      SC_STEP: begin
        if (x_fit) begin
          x_d     = x_nx[POS_LEN-1:0];
          state_d = SC_MOVE;
        end else if (y_fit) begin
          x_d     = XLO;
          y_d     = y_nx[POS_LEN-1:0];
          state_d = SC_MOVE;
        end else begin
          state_d = SC_FIN;
        end
        px_d = x_d;
        py_d = y_d;
      end
      SC_FIN: begin
        state_d = SC_IDLE;
      end
      default: state_d = SC_IDLE;
    endcase
    // outside a record, abort stops at once
    if (abort && state_q != SC_IDLE && state_q != SC_SEND
        && state_q != SC_FIN) begin
      state_d = SC_IDLE;
    end
    if (state_d == SC_IDLE || state_d == SC_FIN) begin
      px_d = PK;
      py_d = PK;
    end
  end

  // Moore outputs and record handoff
  always_comb begin
    busy      = (state_q != SC_IDLE);
    done      = (state_q == SC_FIN);
    hc_en     = (state_q == SC_TRIG);
    rec_start = (state_q == SC_WAIT) && (state_d == SC_SEND);
    rec_abort = abort && (state_q == SC_SEND);
  end

  scan_rec_tx u_rec (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (rec_start),
    .rec       (rec),
    .abort_req (rec_abort),
    .done      (rec_done),
    .aborted   (rec_aborted),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_busy   (tx_busy)
  );

endmodule

// File: tb/tb_scan_sched.sv
// Directed bench for scan_sched: two instances with
// hcsr04 and serial_t behavioural models.
module tb_scan_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  start = '0;
  logic [1:0]  abort = '0;
  logic [1:0]  busy, done, hc_en, tx_send, tx_busy;
  logic [1:0]  hc_done;
  logic [7:0]  pos_x [2];
  logic [7:0]  pos_y [2];
  logic [7:0]  tx_data [2];
  logic [15:0] hc_len = 16'h1234;
  int          hc_dly = 5;
  bit          hc_never = 1'b0;
  int          hc_cnt [2];
  int          ser_cnt [2];

  assign tx_busy[0] = (ser_cnt[0] != 0);
  assign tx_busy[1] = (ser_cnt[1] != 0);

  scan_sched #(
    .X_MIN(50), .X_MAX(70), .X_STEP(10),
    .Y_MIN(50), .Y_MAX(60), .Y_STEP(10),
    .SETTLE_CYC(20), .MEAS_TO(60)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .start(start[0]), .abort(abort[0]),
    .busy(busy[0]), .done(done[0]),
    .pos_x(pos_x[0]), .pos_y(pos_y[0]),
    .hc_en(hc_en[0]), .hc_done(hc_done[0]),
    .hc_len(hc_len),
    .tx_data(tx_data[0]), .tx_send(tx_send[0]),
    .tx_busy(tx_busy[0])
  );

  scan_sched #(
    .X_MIN(200), .X_MAX(255), .X_STEP(10),
    .Y_MIN(50), .Y_MAX(50), .Y_STEP(10),
    .SETTLE_CYC(5), .MEAS_TO(60)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .start(start[1]), .abort(abort[1]),
    .busy(busy[1]), .done(done[1]),
    .pos_x(pos_x[1]), .pos_y(pos_y[1]),
    .hc_en(hc_en[1]), .hc_done(hc_done[1]),
    .hc_len(hc_len),
    .tx_data(tx_data[1]), .tx_send(tx_send[1]),
    .tx_busy(tx_busy[1])
  );

  // hcsr04: done level clears on trigger, rises hc_dly later
  // serial_t: busy for 4 cycles after each send strobe
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_done <= '0;
      hc_cnt  <= '{0, 0};
      ser_cnt <= '{0, 0};
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (hc_en[g]) begin
          hc_done[g] <= 1'b0;
          hc_cnt[g]  <= hc_dly;
        end else if (hc_cnt[g] != 0) begin
          hc_cnt[g] <= hc_cnt[g] - 1;
          if (hc_cnt[g] == 1 && !hc_never) hc_done[g] <= 1'b1;
        end
        if (tx_send[g]) ser_cnt[g] <= 4;
        else if (ser_cnt[g] != 0) ser_cnt[g] <= ser_cnt[g] - 1;
      end
    end
  end

  logic [7:0] log_b [2][0:255];
  int         nb [2] = '{0, 0};
  int         nh [2] = '{0, 0};
  int         nd [2] = '{0, 0};
  logic [1:0] hc_prev = '0;

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (tx_send[g] && nb[g] < 256) begin
        log_b[g][nb[g]] <= tx_data[g];
        nb[g] <= nb[g] + 1;
      end
      if (hc_en[g] && !hc_prev[g]) nh[g] <= nh[g] + 1;
      if (done[g]) nd[g] <= nd[g] + 1;
    end
    hc_prev <= hc_en;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input int g, input int b, input logic [7:0] x,
                         input logic [7:0] y, input logic [15:0] len);
    chk($sformatf("rec%0d_%0d_b0", g, b), 32'(log_b[g][b]),   32'hAD);
    chk($sformatf("rec%0d_%0d_x", g, b),  32'(log_b[g][b+1]), 32'(x));
    chk($sformatf("rec%0d_%0d_y", g, b),  32'(log_b[g][b+2]), 32'(y));
    chk($sformatf("rec%0d_%0d_hi", g, b), 32'(log_b[g][b+3]), 32'(len[15:8]));
    chk($sformatf("rec%0d_%0d_lo", g, b), 32'(log_b[g][b+4]), 32'(len[7:0]));
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic pulse_abort(input int g);
    abort[g] = 1'b1;
    @(negedge clk);
    abort[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int budget);
    int n = 0;
    while (busy[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy[g]), 32'd0);
  endtask

  task automatic wait_nb(input int g, input int target, input int budget);
    int n = 0;
    while (nb[g] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("bytes_timeout", 32'(nb[g] >= target), 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_reset(input int g, input string tag);
    chk({tag, "_busy"}, 32'(busy[g]), 32'd0);
    chk({tag, "_done"}, 32'(done[g]), 32'd0);
    chk({tag, "_hc_en"}, 32'(hc_en[g]), 32'd0);
    chk({tag, "_send"}, 32'(tx_send[g]), 32'd0);
    chk({tag, "_data"}, 32'(tx_data[g]), 32'd0);
    chk({tag, "_px"}, 32'(pos_x[g]), 32'd150);
    chk({tag, "_py"}, 32'(pos_y[g]), 32'd150);
  endtask

  initial begin
    int b, h, d, lat, n;

    // reset state
    wait_cycles(3);
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");
    rst_n = 1'b1;
    wait_cycles(2);

    // 1: full 3x2 scan, hcsr04 returns 0x1234
    b = nb[0]; h = nh[0]; d = nd[0];
    pulse_start(0);
    chk("t1_busy", 32'(busy[0]), 32'd1);
    chk("t1_move_x", 32'(pos_x[0]), 32'd50);
    chk("t1_move_y", 32'(pos_y[0]), 32'd50);
    lat = 0;
    while (!hc_en[0] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("t1_trig_lat", 32'(lat), 32'd21);
    wait_idle(0, 3000);
    wait_cycles(2);
    chk("t1_nbytes", 32'(nb[0] - b), 32'd30);
    for (int yi = 0; yi < 2; yi++)
      for (int xi = 0; xi < 3; xi++)
        chk_rec(0, b + 5 * (yi * 3 + xi), 8'(50 + 10 * xi),
                8'(50 + 10 * yi), 16'h1234);
    chk("t1_done", 32'(nd[0] - d), 32'd1);
    chk("t1_hc", 32'(nh[0] - h), 32'd6);
    chk("t1_park_x", 32'(pos_x[0]), 32'd150);
    chk("t1_park_y", 32'(pos_y[0]), 32'd150);

    // 2: hc_done never rises -> timeout record, scan continues
    hc_never = 1'b1;
    b = nb[0]; d = nd[0];
    pulse_start(0);
    wait_nb(0, b + 5, 800);
    chk_rec(0, b, 8'd50, 8'd50, 16'hFFFF);
    wait_nb(0, b + 10, 800);
    chk_rec(0, b + 5, 8'd60, 8'd50, 16'hFFFF);
    pulse_abort(0);
    wait_idle(0, 500);
    wait_cycles(2);
    chk("t2_nbytes", 32'(nb[0] - b), 32'd10);
    chk("t2_done", 32'(nd[0] - d), 32'd0);
    hc_never = 1'b0;

    // 3: abort during SETTLE of point 2
    b = nb[0]; h = nh[0]; d = nd[0];
    pulse_start(0);
    n = 0;
    while (pos_x[0] != 8'd60 && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk("t3_reach_p2", 32'(pos_x[0]), 32'd60);
    wait_cycles(3);
    pulse_abort(0);
    chk("t3_px", 32'(pos_x[0]), 32'd150);
    chk("t3_py", 32'(pos_y[0]), 32'd150);
    chk("t3_busy", 32'(busy[0]), 32'd0);
    chk("t3_hc_en", 32'(hc_en[0]), 32'd0);
    wait_cycles(100);
    chk("t3_hc", 32'(nh[0] - h), 32'd1);
    chk("t3_nbytes", 32'(nb[0] - b), 32'd5);
    chk("t3_done", 32'(nd[0] - d), 32'd0);

    // 4: abort while byte 2 is in flight
    b = nb[0]; h = nh[0]; d = nd[0];
    pulse_start(0);
    wait_nb(0, b + 3, 800);
    pulse_abort(0);
    wait_idle(0, 500);
    wait_cycles(50);
    chk("t4_nbytes", 32'(nb[0] - b), 32'd5);
    chk_rec(0, b, 8'd50, 8'd50, 16'h1234);
    chk("t4_hc", 32'(nh[0] - h), 32'd1);
    chk("t4_done", 32'(nd[0] - d), 32'd0);
    chk("t4_px", 32'(pos_x[0]), 32'd150);

    // 5: X_MAX=255 stops at 250, restart while busy ignored
    b = nb[1]; h = nh[1]; d = nd[1];
    pulse_start(1);
    chk("t5_move_x", 32'(pos_x[1]), 32'd200);
    wait_cycles(10);
    pulse_start(1);
    wait_idle(1, 3000);
    wait_cycles(2);
    chk("t5_nbytes", 32'(nb[1] - b), 32'd30);
    for (int xi = 0; xi < 6; xi++)
      chk_rec(1, b + 5 * xi, 8'(200 + 10 * xi), 8'd50, 16'h1234);
    chk("t5_done", 32'(nd[1] - d), 32'd1);
    chk("t5_hc", 32'(nh[1] - h), 32'd6);

    // 6: reset mid-WAIT, then a full scan
    hc_dly = 30;
    h = nh[0];
    pulse_start(0);
    n = 0;
    while (nh[0] == h && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_trig", 32'(nh[0] - h), 32'd1);
    wait_cycles(5);
    chk("t6_busy_pre", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset(0, "t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    hc_dly = 5;
    wait_cycles(2);
    b = nb[0]; d = nd[0];
    pulse_start(0);
    wait_idle(0, 3000);
    wait_cycles(2);
    chk("t6_nbytes", 32'(nb[0] - b), 32'd30);
    chk_rec(0, b, 8'd50, 8'd50, 16'h1234);
    chk_rec(0, b + 25, 8'd70, 8'd60, 16'h1234);
    chk("t6_done", 32'(nd[0] - d), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
